// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART transmitter with a fixed 50 MHz baud divisor table.
// A single-cycle send_en starts a frame; data and baud select are latched at
// acceptance, so the inputs may change freely while the frame is on the line.
module uart_byte_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_en,
  input  logic [7:0] data_byte,
  input  logic [2:0] baud_set,
  output logic       rs232_tx,
  output logic       tx_done,
  output logic       uart_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bit period is DIV+1 clk cycles at 50 MHz. Unused selects fall back to 9600.
  localparam logic [15:0] DIV_9600   = 16'd5207;
  localparam logic [15:0] DIV_19200  = 16'd2603;
  localparam logic [15:0] DIV_38400  = 16'd1301;
  localparam logic [15:0] DIV_57600  = 16'd867;
  localparam logic [15:0] DIV_115200 = 16'd433;

  function automatic logic [15:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd0:    return DIV_9600;
      3'd1:    return DIV_19200;
      3'd2:    return DIV_38400;
      3'd3:    return DIV_57600;
      3'd4:    return DIV_115200;
      default: return DIV_9600;
    endcase
  endfunction

  state_t      state_q,   state_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q,    data_d;
  logic [15:0] div_q,     div_d;
  logic        tx_q,      tx_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;

  logic        bit_end;
  logic [2:0]  bit_idx_inc;

  assign bit_end     = (cnt_q == div_q);
  assign bit_idx_inc = bit_idx_q + 3'd1;

  // Next-state and next-output logic; every registered output is computed here
  // and then captured in the state register so the line never glitches.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    div_d     = div_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (send_en) begin
          state_d   = START;
          data_d    = data_byte;
          div_d     = baud_div(baud_set);
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          cnt_d     = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_inc;
            tx_d      = data_q[bit_idx_inc];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register: all state, including the line driver, on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      div_q     <= DIV_9600;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rs232_tx  = tx_q;
  assign uart_busy = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx. The reference model is a frame
// description: line level for cycle k of a frame is bit k/P of {1, data, 0}
// sent from the low end, with P taken from the baud table.
module tb_uart_byte_tx;

  logic       clk;
  logic       rst_n;
  logic       send_en;
  logic [7:0] data_byte;
  logic [2:0] baud_set;
  logic       rs232_tx;
  logic       tx_done;
  logic       uart_busy;

  int total;
  int bad;

  uart_byte_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_en   (send_en),
    .data_byte (data_byte),
    .baud_set  (baud_set),
    .rs232_tx  (rs232_tx),
    .tx_done   (tx_done),
    .uart_busy (uart_busy)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Bit period in clk cycles for a baud select, from the baud table.
  function automatic int period_of(input logic [2:0] sel);
    case (sel)
      3'd0:    return 5208;
      3'd1:    return 2604;
      3'd2:    return 1302;
      3'd3:    return 868;
      3'd4:    return 434;
      default: return 5208;
    endcase
  endfunction

  // Expected line level for frame bit j (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic exp_line(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return d[j-1];
  endfunction

  // Runs one frame from the current negedge. Options: pulse send_en with 0xFF at
  // cycle inject_at, change baud_set at rebaud_at, assert reset at abort_at, or
  // request the next frame (chain_d) in the tx_done cycle.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [2:0] b,
                           input bit already_sent, input int inject_at,
                           input int rebaud_at, input logic [2:0] rebaud_val,
                           input int abort_at, input bit chain, input logic [7:0] chain_d);
    int   p;
    bit   bit_err;
    bit   ctrl_err;
    logic bit_act;
    p = period_of(b);
    bit_err  = 1'b0;
    ctrl_err = 1'b0;
    bit_act  = 1'b0;
    if (!already_sent) begin
      send_en   = 1'b1;
      data_byte = d;
      baud_set  = b;
    end
    @(negedge clk);
    send_en = 1'b0;

    total++;
    if (rs232_tx !== 1'b0 || uart_busy !== 1'b1) begin
      bad++;
      $display("FAIL %s start_latency: tx=%b busy=%b want tx=0 busy=1", name, rs232_tx, uart_busy);
    end

    for (int k = 0; k <= 10 * p; k++) begin
      if (k > 0) @(negedge clk);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        total++;
        if (rs232_tx !== 1'b1 || uart_busy !== 1'b0 || tx_done !== 1'b0) begin
          bad++;
          $display("FAIL %s abort: tx=%b busy=%b done=%b want 1 0 0", name, rs232_tx, uart_busy, tx_done);
        end
        return;
      end
      if (k < 10 * p) begin
        if (rs232_tx !== exp_line(d, k / p) && !bit_err) begin
          bit_err = 1'b1;
          bit_act = rs232_tx;
        end
        if (uart_busy !== 1'b1 || tx_done !== 1'b0) ctrl_err = 1'b1;
        if (k % p == p - 1) begin
          total++;
          if (bit_err) begin
            bad++;
            $display("FAIL %s bit%0d: line saw %b want %b for %0d cycles", name, k / p, bit_act, exp_line(d, k / p), p);
          end
          bit_err = 1'b0;
        end
        if (k == inject_at) begin
          send_en   = 1'b1;
          data_byte = 8'hFF;
        end else begin
          send_en = 1'b0;
        end
        if (k == rebaud_at) baud_set = rebaud_val;
      end else begin
        total++;
        if (ctrl_err) begin
          bad++;
          $display("FAIL %s in_frame_ctrl: busy dropped or tx_done pulsed before %0d cycles", name, 10 * p);
        end
        total++;
        if (tx_done !== 1'b1 || uart_busy !== 1'b0 || rs232_tx !== 1'b1) begin
          bad++;
          $display("FAIL %s frame_end: done=%b busy=%b tx=%b want 1 0 1", name, tx_done, uart_busy, rs232_tx);
        end
        if (chain) begin
          send_en   = 1'b1;
          data_byte = chain_d;
        end
      end
    end

    if (!chain) begin
      @(negedge clk);
      total++;
      if (tx_done !== 1'b0 || uart_busy !== 1'b0 || rs232_tx !== 1'b1) begin
        bad++;
        $display("FAIL %s after_end: done=%b busy=%b tx=%b want 0 0 1", name, tx_done, uart_busy, rs232_tx);
      end
    end
  endtask

  // Reset values, then a send on the first edge after release (0x55 at 115200).
  task automatic test_reset;
    rst_n     = 1'b0;
    send_en   = 1'b0;
    data_byte = 8'h00;
    baud_set  = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if (rs232_tx !== 1'b1 || uart_busy !== 1'b0 || tx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b want 1 0 0", rs232_tx, uart_busy, tx_done);
    end
    rst_n = 1'b1;
    run_frame("first_after_reset_55", 8'h55, 3'd4, 1'b0, -1, -1, 3'd0, -1, 1'b0, 8'h00);
  endtask

  // 0xA3 at 9600 with a 0xFF request mid-frame that must be ignored.
  task automatic test_ignore_busy;
    run_frame("ignore_busy_a3", 8'hA3, 3'd0, 1'b0, 5 * 5208 + 17, -1, 3'd0, -1, 1'b0, 8'h00);
  endtask

  // 0x01 at 57600 then 0x80 requested in the tx_done cycle.
  task automatic test_back_to_back;
    run_frame("b2b_first_01", 8'h01, 3'd3, 1'b0, -1, -1, 3'd0, -1, 1'b1, 8'h80);
    run_frame("b2b_second_80", 8'h80, 3'd3, 1'b1, -1, -1, 3'd0, -1, 1'b0, 8'h00);
  endtask

  // Baud change mid-frame is ignored; select 6 on the next send gives 5208 cycles.
  task automatic test_baud_latch;
    logic [7:0] d;
    d = 8'($urandom);
    run_frame("rebaud_mid_frame", d, 3'd4, 1'b0, -1, 3 * 434 + 5, 3'd0, -1, 1'b0, 8'h00);
    d = 8'($urandom);
    run_frame("baud6_start_bit", d, 3'd6, 1'b0, -1, -1, 3'd0, 5208 + 3, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reset during data bit 3 aborts the frame; a random frame then goes out cleanly.
  task automatic test_reset_abort;
    logic [7:0] d;
    d = 8'($urandom);
    run_frame("abort_in_bit3", d, 3'd4, 1'b0, -1, -1, 3'd0, 4 * 434 + 100, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    total++;
    if (tx_done !== 1'b0 || rs232_tx !== 1'b1) begin
      bad++;
      $display("FAIL abort_hold: done=%b tx=%b want 0 1", tx_done, rs232_tx);
    end
    rst_n = 1'b1;
    d = 8'($urandom);
    run_frame("after_abort_random", d, 3'd4, 1'b0, -1, -1, 3'd0, -1, 1'b0, 8'h00);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_ignore_busy();
    test_back_to_back();
    test_baud_latch();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
